idli_sqi_arb_m: RTL and testbench

Shares the single SQI SRAM port between the instruction-fetch requester (F) and the load/store requester (D). The block arbitrates between the two with round-robin priority and sequences each complete SQI transaction: command, 24-bit address, dummy and 16-bit data nibbles. It returns read data as a parallel word. It sits between the core control/LSU logic and the SQI pads, replacing the fixed always-read wiring of the SQI controller.

---
 rtl/idli_sqi_arb_m.sv | 198 +++++++++++++++++++
 tb/tb_idli_sqi_arb_m.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_arb_m.sv
// Round-robin arbiter and transaction sequencer for the shared SQI SRAM port.
// Fetch (F) issues reads only; data (D) issues reads or writes. Each granted
// request becomes one complete SQI transaction: command, 24-bit address,
// dummy nibbles (reads only) and four data nibbles.
//
// Handshake: a requester raises req with its address/data and holds them
// until acp. acp is a one-cycle combinational pulse in an IDLE cycle, and the
// request is consumed on that clock edge. A req that drops before acp is
// simply never granted. Requests seen outside IDLE are ignored until IDLE.
module idli_sqi_arb_m #(
  parameter logic [7:0] CMD_RD    = 8'h03,
  parameter logic [7:0] CMD_WR    = 8'h02,
  parameter int         DUMMY_NIB = 2
) (
  input  logic        i_sab_gck,
  input  logic        i_sab_rst,
  input  logic        i_sab_f_req,
  input  logic [15:0] i_sab_f_addr,
  output logic        o_sab_f_acp,
  input  logic        i_sab_d_req,
  input  logic        i_sab_d_wr,
  input  logic [15:0] i_sab_d_addr,
  input  logic [15:0] i_sab_d_wdata,
  output logic        o_sab_d_acp,
  output logic        o_sab_sqi_sck,
  output logic        o_sab_sqi_cs,
  output logic        o_sab_sqi_mode,
  output logic [3:0]  o_sab_sqi_data,
  input  logic [3:0]  i_sab_sqi_data,
  output logic [15:0] o_sab_rd_data,
  output logic        o_sab_rd_vld,
  output logic        o_sab_rd_src,
  output logic        o_sab_busy,
  output logic [2:0]  o_sab_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DESEL = 3'd5
  } state_t;

  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIB - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_d_q;
  logic        wr_q, wr_n;
  logic        src_q;
  logic [15:0] addr_q, addr_n;
  logic [15:0] wdata_q, wdata_n;
  logic [15:0] rd_buf_q;
  logic        idle;
  logic [7:0]  cmd_byte;
  logic [23:0] addr24;
  logic [3:0]  nib_d;
  logic        mode_d;
  logic        active_d;

  // Arbitration: on a tie the requester not granted last wins.
  assign idle        = (state_q == ST_IDLE) && !i_sab_rst;
  assign o_sab_f_acp = idle && i_sab_f_req && (!i_sab_d_req || last_d_q);
  assign o_sab_d_acp = idle && i_sab_d_req && (!i_sab_f_req || !last_d_q);
  assign o_sab_state = state_q;

  // Next state, capture values and the pad values for the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 3'd1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        if (o_sab_f_acp || o_sab_d_acp) state_d = ST_CMD;
      end
      ST_CMD: if (cnt_q == 3'd1) begin
        state_d = ST_ADDR;
        cnt_d   = 3'd0;
      end
      ST_ADDR: if (cnt_q == 3'd5) begin
        state_d = wr_q ? ST_DATA : ST_DUMMY;
        cnt_d   = 3'd0;
      end
      ST_DUMMY: if (cnt_q == DUMMY_LAST) begin
        state_d = ST_DATA;
        cnt_d   = 3'd0;
      end
      ST_DATA: if (cnt_q == 3'd3) begin
        state_d = ST_DESEL;
        cnt_d   = 3'd0;
      end
      ST_DESEL: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Values the capture registers will hold once this edge is taken.
    wr_n    = wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    if (o_sab_d_acp) begin
      wr_n    = i_sab_d_wr;
      addr_n  = i_sab_d_addr;
      wdata_n = i_sab_d_wdata;
    end else if (o_sab_f_acp) begin
      wr_n   = 1'b0;
      addr_n = i_sab_f_addr;
    end

    cmd_byte = wr_n ? CMD_WR : CMD_RD;
    addr24   = {8'h00, addr_n};
    nib_d    = 4'h0;
    unique case (state_d)
      ST_CMD:  nib_d = cnt_d[0] ? cmd_byte[3:0] : cmd_byte[7:4];
      ST_ADDR: begin
        case (cnt_d)
          3'd0:    nib_d = addr24[23:20];
          3'd1:    nib_d = addr24[19:16];
          3'd2:    nib_d = addr24[15:12];
          3'd3:    nib_d = addr24[11:8];
          3'd4:    nib_d = addr24[7:4];
          default: nib_d = addr24[3:0];
        endcase
      end
      ST_DATA: if (wr_n) begin
        case (cnt_d[1:0])
          2'd0:    nib_d = wdata_n[7:4];
          2'd1:    nib_d = wdata_n[3:0];
          2'd2:    nib_d = wdata_n[15:12];
          default: nib_d = wdata_n[11:8];
        endcase
      end
      default: nib_d = 4'h0;
    endcase

    active_d = (state_d == ST_CMD) || (state_d == ST_ADDR) ||
               (state_d == ST_DUMMY) || (state_d == ST_DATA);
    mode_d   = (state_d == ST_DUMMY) || ((state_d == ST_DATA) && !wr_n);
  end

  // State, captured request, registered pad outputs and read assembly.
  always_ff @(posedge i_sab_gck) begin
    if (i_sab_rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 3'd0;
      last_d_q       <= 1'b1;
      wr_q           <= 1'b0;
      src_q          <= 1'b0;
      addr_q         <= 16'h0000;
      wdata_q        <= 16'h0000;
      rd_buf_q       <= 16'h0000;
      o_sab_sqi_sck  <= 1'b0;
      o_sab_sqi_cs   <= 1'b1;
      o_sab_sqi_mode <= 1'b0;
      o_sab_sqi_data <= 4'h0;
      o_sab_rd_data  <= 16'h0000;
      o_sab_rd_vld   <= 1'b0;
      o_sab_rd_src   <= 1'b0;
      o_sab_busy     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_q           <= wr_n;
      addr_q         <= addr_n;
      wdata_q        <= wdata_n;
      o_sab_sqi_sck  <= active_d;
      o_sab_sqi_cs   <= !active_d;
      o_sab_sqi_mode <= mode_d;
      o_sab_sqi_data <= nib_d;
      o_sab_busy     <= (state_d != ST_IDLE);
      o_sab_rd_vld   <= 1'b0;
      if (o_sab_f_acp || o_sab_d_acp) begin
        last_d_q <= o_sab_d_acp;
        src_q    <= o_sab_d_acp;
      end
      if ((state_q == ST_DATA) && !wr_q) begin
        case (cnt_q[1:0])
          2'd0: rd_buf_q[7:4]   <= i_sab_sqi_data;
          2'd1: rd_buf_q[3:0]   <= i_sab_sqi_data;
          2'd2: rd_buf_q[15:12] <= i_sab_sqi_data;
          default: begin
            o_sab_rd_data <= {rd_buf_q[15:12], i_sab_sqi_data, rd_buf_q[7:0]};
            o_sab_rd_src  <= src_q;
            o_sab_rd_vld  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Bench for idli_sqi_arb_m: directed transactions, expected nibble streams,
// grants and read words queued at issue time and checked by a monitor.
module tb_idli_sqi_arb_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_acp;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_acp;
  logic        sqi_sck;
  logic        sqi_cs;
  logic        sqi_mode;
  logic [3:0]  sqi_out;
  logic [3:0]  sqi_in;
  logic [15:0] rd_data;
  logic        rd_vld;
  logic        rd_src;
  logic        busy;
  logic [2:0]  dbg_state;

  idli_sqi_arb_m dut (
    .i_sab_gck      (clk),
    .i_sab_rst      (rst),
    .i_sab_f_req    (f_req),
    .i_sab_f_addr   (f_addr),
    .o_sab_f_acp    (f_acp),
    .i_sab_d_req    (d_req),
    .i_sab_d_wr     (d_wr),
    .i_sab_d_addr   (d_addr),
    .i_sab_d_wdata  (d_wdata),
    .o_sab_d_acp    (d_acp),
    .o_sab_sqi_sck  (sqi_sck),
    .o_sab_sqi_cs   (sqi_cs),
    .o_sab_sqi_mode (sqi_mode),
    .o_sab_sqi_data (sqi_out),
    .i_sab_sqi_data (sqi_in),
    .o_sab_rd_data  (rd_data),
    .o_sab_rd_vld   (rd_vld),
    .o_sab_rd_src   (rd_src),
    .o_sab_busy     (busy),
    .o_sab_state    (dbg_state)
  );

  // Clock
  initial forever #5 clk = ~clk;

  // Scoreboard queues: stream entries are {care_data, mode, nibble},
  // grants are {timed_read, src}, read words are {src, data}.
  logic [5:0]  exp_q[$];
  logic [1:0]  grant_q[$];
  logic [16:0] rd_q[$];
  int          acp_cyc_q[$];
  logic [3:0]  sram_nib[4];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acp = 0;
  int last_acp_cyc = 0;
  int cs_hi_run = 0;
  int sram_cnt = 0;
  bit prev_txn = 0;
  bit gap_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_nib(input logic care, input logic mode, input logic [3:0] nib);
    exp_q.push_back({care, mode, nib});
  endtask

  task automatic push_hdr(input logic [7:0] cmd, input logic [15:0] addr);
    push_nib(1, 0, cmd[7:4]);
    push_nib(1, 0, cmd[3:0]);
    push_nib(1, 0, 4'h0);
    push_nib(1, 0, 4'h0);
    push_nib(1, 0, addr[15:12]);
    push_nib(1, 0, addr[11:8]);
    push_nib(1, 0, addr[7:4]);
    push_nib(1, 0, addr[3:0]);
  endtask

  task automatic push_read(input logic [15:0] addr);
    push_hdr(8'h03, addr);
    for (int i = 0; i < 6; i++) push_nib(0, 1, 4'h0);
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] wd);
    push_hdr(8'h02, addr);
    push_nib(1, 0, wd[7:4]);
    push_nib(1, 0, wd[3:0]);
    push_nib(1, 0, wd[15:12]);
    push_nib(1, 0, wd[11:8]);
  endtask

  // Monitor: pad stream, cs gaps, grants and read completions.
  task automatic monitor_loop();
    logic [5:0]  e;
    logic [1:0]  g;
    logic [16:0] r;
    int          t;
    forever begin
      @(negedge clk);
      if (sqi_cs === 1'b0) begin
        if (gap_chk && prev_txn && cs_hi_run != 0) chk("cs_gap", cs_hi_run, 2);
        cs_hi_run = 0;
        prev_txn  = 1;
        if (exp_q.size() == 0) begin
          chk("stream_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sqi_pads", {sqi_sck, sqi_mode, (e[5] ? sqi_out : e[3:0])}, {1'b1, e[4], e[3:0]});
        end
      end else begin
        cs_hi_run++;
      end
      if (f_acp === 1'b1 || d_acp === 1'b1) begin
        n_acp++;
        last_acp_cyc = cyc;
        if (f_acp === 1'b1 && d_acp === 1'b1) chk("double_acp", 1, 0);
        if (grant_q.size() == 0) begin
          chk("grant_extra", 1, 0);
        end else begin
          g = grant_q.pop_front();
          chk("grant_src", d_acp, g[0]);
          if (g[1]) acp_cyc_q.push_back(cyc);
        end
      end
      if (rd_vld === 1'b1) begin
        if (rd_q.size() == 0) begin
          chk("rd_vld_extra", 1, 0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_word", {rd_src, rd_data}, r);
          if (acp_cyc_q.size() == 0) begin
            chk("rd_latency_missing", 1, 0);
          end else begin
            t = acp_cyc_q.pop_front();
            chk("rd_latency", cyc - t, 15);
          end
        end
      end
    end
  endtask

  // SRAM model: drives read nibbles during the four DATA cycles of a read.
  task automatic sram_loop();
    int idx;
    forever begin
      @(negedge clk);
      if (sqi_cs === 1'b0) begin
        idx = sram_cnt;
        sram_cnt++;
        sqi_in = (idx >= 10 && idx <= 13) ? sram_nib[idx - 10] : 4'h0;
      end else begin
        sram_cnt = 0;
        sqi_in   = 4'h0;
      end
    end
  endtask

  task automatic cycle_loop();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic wait_acp(input int n);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      if (n_acp >= n) break;
    end
    if (k == 200) chk("acp_timeout", n_acp, n);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      if (busy === 1'b0) break;
    end
    if (k == 200) chk("idle_timeout", busy, 0);
  endtask

  int f_cyc;

  // Stimulus
  initial begin
    rst = 1; f_req = 1; f_addr = 16'h1234;
    d_req = 1; d_wr = 1; d_addr = 16'h0010; d_wdata = 16'h5678;
    sqi_in = 4'h0;
    sram_nib[0] = 4'hA; sram_nib[1] = 4'hB; sram_nib[2] = 4'hC; sram_nib[3] = 4'hD;
    fork
      monitor_loop();
      sram_loop();
      cycle_loop();
    join_none

    // Reset with both requests high
    @(posedge clk);
    @(negedge clk);
    chk("rst_cs", sqi_cs, 1);
    chk("rst_sck", sqi_sck, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mode", sqi_mode, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_f_acp", f_acp, 0);
    chk("rst_d_acp", d_acp, 0);

    // Arbitration with both held: F, D, F, D and 2-cycle cs gaps
    grant_q.push_back(2'b10); push_read(16'h1234);        rd_q.push_back({1'b0, 16'hCDAB});
    grant_q.push_back(2'b01); push_write(16'h0010, 16'h5678);
    grant_q.push_back(2'b10); push_read(16'h1234);        rd_q.push_back({1'b0, 16'hCDAB});
    grant_q.push_back(2'b01); push_write(16'h0010, 16'h5678);
    gap_chk = 1;
    @(posedge clk);
    #1 rst = 0;
    wait_acp(4);
    #1 f_req = 0; d_req = 0;
    wait_idle();
    gap_chk = 0;
    repeat (3) @(posedge clk);

    // Late arrival: D read raised mid F read, granted only after DESEL
    sram_nib[0] = 4'h5; sram_nib[1] = 4'h6; sram_nib[2] = 4'h7; sram_nib[3] = 4'h8;
    grant_q.push_back(2'b10); push_read(16'h0ACE); rd_q.push_back({1'b0, 16'h7856});
    grant_q.push_back(2'b11); push_read(16'h0011); rd_q.push_back({1'b1, 16'h7856});
    #1 f_addr = 16'h0ACE; f_req = 1;
    wait_acp(5);
    f_cyc = last_acp_cyc;
    #1 f_req = 0;
    repeat (5) @(posedge clk);
    #1 d_req = 1; d_wr = 0; d_addr = 16'h0011;
    wait_acp(6);
    chk("late_acp_delay", last_acp_cyc - f_cyc, 16);
    #1 d_req = 0;
    wait_idle();
    repeat (2) @(posedge clk);

    // Reset in the 3rd ADDR cycle of a read
    grant_q.push_back(2'b00);
    push_nib(1, 0, 4'h0); push_nib(1, 0, 4'h3);
    push_nib(1, 0, 4'h0); push_nib(1, 0, 4'h0); push_nib(1, 0, 4'h0);
    #1 f_addr = 16'h00FF; f_req = 1;
    wait_acp(7);
    #1 f_req = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_cs", sqi_cs, 1);
    chk("abort_sck", sqi_sck, 0);
    chk("abort_mode", sqi_mode, 0);
    chk("abort_busy", busy, 0);

    // Fresh write after the abort
    grant_q.push_back(2'b01); push_write(16'hFFFE, 16'hBEEF);
    @(posedge clk);
    #1 d_req = 1; d_wr = 1; d_addr = 16'hFFFE; d_wdata = 16'hBEEF;
    wait_acp(8);
    #1 d_req = 0;
    wait_idle();
    repeat (25) @(posedge clk);

    chk("stream_left", exp_q.size(), 0);
    chk("grants_left", grant_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    chk("latency_left", acp_cyc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
